wb_regfile_sb: RTL and testbench
================================

Name: wb_regfile_sb

Overview:
- Write-back end of the MEM/WB pipeline interface: consumes the registered MEM/WB outputs and selects load data or ALU result.
- Commits the selected value into a 32x32 register file.
- Provides two combinational read ports to the decode stage.
- Keeps a load scoreboard (one pending bit per register) so decode can detect load-use hazards and stall.

Parameters:
- NREG, 32, number of architectural registers (register 0 hardwired to zero).
- XLEN, 32, data width.
- AW, 5, register index width (log2 NREG).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Mem_Read_Data_WB  in  XLEN  load data from MEM/WB.
- Reg_File_Data_WB  in  XLEN  ALU result from MEM/WB.
- wb_rd  in  AW  destination register index from MEM/WB.
- control_signals  in  3  from MEM/WB: [2]=RegWrite, [1]=MemtoReg, [0]=MemWrite (ignored here).
- rs_addr  in  AW  decode read port A index.
- rt_addr  in  AW  decode read port B index.
- rs_data  out  XLEN  read port A data.
- rt_data  out  XLEN  read port B data.
- rs_busy  out  1  rs has an outstanding load.
- rt_busy  out  1  rt has an outstanding load.
- ld_issue  in  1  a load leaves decode this cycle.
- ld_issue_rd  in  AW  destination of that load.
- flush  in  1  pipeline flush; clears the scoreboard.
- wb_fwd_valid  out  1  a write-back is committing this cycle.
- wb_fwd_rd  out  AW  index being written.
- wb_fwd_data  out  XLEN  value being written (forwarding source for EX).

Behaviour:
- Reset (async, rst=1):
  - All registers = 0.
  - All scoreboard bits = 0.
  - Writes and scoreboard updates are suppressed while rst is high.
  - Reset arriving mid-load drops the pending state; no residual busy.
- Write-back data select:
  - wb_data = MemtoReg ? Mem_Read_Data_WB : Reg_File_Data_WB.
  - Pure combinational mux.
- Write enable:
  - we = RegWrite && (wb_rd != 0).
  - On the rising edge with we=1, reg[wb_rd] <= wb_data.
  - Latency: value is architecturally visible the cycle after the edge.
  - MemWrite has no effect.
- Forward outputs:
  - wb_fwd_valid = we, wb_fwd_rd = wb_rd, wb_fwd_data = wb_data.
  - All combinational.
  - wb_fwd_rd and wb_fwd_data are don't-care when wb_fwd_valid=0, but are still driven.
- Read ports:
  - Combinational.
  - Index 0 always returns 0.
  - Read-during-write behaviour is set by WB_BYPASS_EN.
- Scoreboard (NREG bits, bit 0 tied 0):
  - Set: ld_issue && ld_issue_rd != 0 sets sb[ld_issue_rd] at the edge.
  - Clear: we && MemtoReg clears sb[wb_rd] at the edge.
  - Same index set and cleared in the same cycle: set wins (newer load is still outstanding).
  - Different indices set and cleared in the same cycle: both take effect.
  - flush=1: all bits cleared at the edge; flush has priority over set.
  - A load to an already-busy index keeps the bit set; there is no count. Pipeline ordering guarantees in-order write-back.
- Busy outputs:
  - rs_busy = sb[rs_addr] && !(we && MemtoReg && wb_rd == rs_addr); same form for rt_busy.
  - The returning load is therefore never reported busy in its own write-back cycle.
  - Index 0 is never busy.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: read port with index == wb_rd, we=1 and index != 0 returns wb_data in the same cycle (write-through).
- Undefined: read port returns the stored (old) value during the write cycle; the EX forwarding path uses wb_fwd_* instead.
- Busy masking is identical in both builds.

Decomposition:
- Shared package mips_pkg:
  - Constants XLEN, AW, NREG.
  - Control-bit index constants CS_REGWRITE=2, CS_MEMTOREG=1, CS_MEMWRITE=0.
  - Typedef reg_idx_t (AW bits) and word_t (XLEN bits).
- One natural sub-module, load_scoreboard: scoreboard bit vector, set/clear/flush logic, and busy outputs.
- The register array and write-back mux stay in the top module.

Test Plan:
- Reset: assert rst mid-run with sb[5]=1 and reg[3]=0xDEAD -> rs_addr=3 reads 0, rs_addr=5 gives rs_busy=0, immediately (async), no clock required.
- ALU write-back: control=3'b100, wb_rd=7, Reg_File_Data_WB=0x1234 -> wb_fwd_valid=1 that cycle; rs_addr=7 reads 0x1234 the next cycle.
- Register 0: control=3'b110, wb_rd=0, Mem_Read_Data_WB=0xFFFF_FFFF -> wb_fwd_valid=0; reg 0 reads 0; ld_issue with ld_issue_rd=0 never makes rs_busy=1.
- Load-use: ld_issue=1, ld_issue_rd=9, then rs_addr=9 -> rs_busy=1 until the cycle with control=3'b110, wb_rd=9, where rs_busy=0 (masked); stays 0 afterwards.
- Simultaneous set and clear on 9 -> sb[9] remains 1. Same with flush=1 -> all busy=0 the next cycle.
- Bypass: wb_rd=4, Reg_File_Data_WB=0xA5A5, RegWrite=1, rt_addr=4 in the same cycle -> rt_data=0xA5A5 with WB_BYPASS_EN defined; rt_data=old value (0) without it.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, control-bit positions and types for the write-back slice
package mips_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    localparam int CS_REGWRITE = 2;
    localparam int CS_MEMTOREG = 1;
    localparam int CS_MEMWRITE = 0;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/wb_regfile_sb_if.sv
// rtl/wb_regfile_sb_if.sv - MEM/WB, decode read/hazard and forwarding signals of the write-back stage
interface wb_regfile_sb_if;
    import mips_pkg::*;

    word_t    Mem_Read_Data_WB;
    word_t    Reg_File_Data_WB;
    reg_idx_t wb_rd;
    logic [2:0] control_signals;
    reg_idx_t rs_addr;
    reg_idx_t rt_addr;
    word_t    rs_data;
    word_t    rt_data;
    logic     rs_busy;
    logic     rt_busy;
    logic     ld_issue;
    reg_idx_t ld_issue_rd;
    logic     flush;
    logic     wb_fwd_valid;
    reg_idx_t wb_fwd_rd;
    word_t    wb_fwd_data;

    modport master (
        output Mem_Read_Data_WB, Reg_File_Data_WB, wb_rd, control_signals,
        output rs_addr, rt_addr, ld_issue, ld_issue_rd, flush,
        input  rs_data, rt_data, rs_busy, rt_busy,
        input  wb_fwd_valid, wb_fwd_rd, wb_fwd_data
    );

    modport slave (
        input  Mem_Read_Data_WB, Reg_File_Data_WB, wb_rd, control_signals,
        input  rs_addr, rt_addr, ld_issue, ld_issue_rd, flush,
        output rs_data, rt_data, rs_busy, rt_busy,
        output wb_fwd_valid, wb_fwd_rd, wb_fwd_data
    );
endinterface

// File: rtl/wb_regfile_sb_load_scoreboard.sv
// rtl/wb_regfile_sb_load_scoreboard.sv - per-register outstanding-load bits and load-use busy flags
module load_scoreboard
    import mips_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     ld_issue,
    input  reg_idx_t ld_issue_rd,
    input  logic     clr_en,
    input  reg_idx_t clr_rd,
    input  logic     flush,
    input  reg_idx_t rs_addr,
    input  reg_idx_t rt_addr,
    output logic     rs_busy,
    output logic     rt_busy
);
    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // Order matters: set after clear so a newer load to the same index stays pending,
    // and flush last so it overrides both.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) begin
            sb_d[clr_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != '0)) begin
            sb_d[ld_issue_rd] = 1'b1;
        end
        if (flush) begin
            sb_d = '0;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // The load returning this cycle is already satisfiable via forwarding.
    assign rs_busy = sb_q[rs_addr] && !(clr_en && (clr_rd == rs_addr));
    assign rt_busy = sb_q[rt_addr] && !(clr_en && (clr_rd == rt_addr));
endmodule

// File: rtl/wb_regfile_sb.sv
// rtl/wb_regfile_sb.sv - write-back mux, 32x32 register file and load scoreboard; WB_BYPASS_EN enables read write-through
module wb_regfile_sb
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    wb_regfile_sb_if.slave        bus
);
    word_t regs_q [NREG];
    word_t regs_d [NREG];
    word_t wb_data;
    logic  we;
    logic  memtoreg;
    logic  memwrite_unused;

    assign memtoreg        = bus.control_signals[CS_MEMTOREG];
    assign memwrite_unused = bus.control_signals[CS_MEMWRITE];
    assign wb_data         = memtoreg ? bus.Mem_Read_Data_WB : bus.Reg_File_Data_WB;
    assign we              = bus.control_signals[CS_REGWRITE] && (bus.wb_rd != '0);

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[bus.wb_rd] = wb_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // we already excludes index 0, so the bypass can never expose a value on r0.
    always_comb begin
        bus.rs_data = regs_q[bus.rs_addr];
        bus.rt_data = regs_q[bus.rt_addr];
`ifdef WB_BYPASS_EN
        if (we && (bus.rs_addr == bus.wb_rd)) begin
            bus.rs_data = wb_data;
        end
        if (we && (bus.rt_addr == bus.wb_rd)) begin
            bus.rt_data = wb_data;
        end
`endif
    end

    assign bus.wb_fwd_valid = we;
    assign bus.wb_fwd_rd    = bus.wb_rd;
    assign bus.wb_fwd_data  = wb_data;

    load_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .ld_issue    (bus.ld_issue),
        .ld_issue_rd (bus.ld_issue_rd),
        .clr_en      (we && memtoreg),
        .clr_rd      (bus.wb_rd),
        .flush       (bus.flush),
        .rs_addr     (bus.rs_addr),
        .rt_addr     (bus.rt_addr),
        .rs_busy     (bus.rs_busy),
        .rt_busy     (bus.rt_busy)
    );
endmodule

// File: tb/tb_wb_regfile_sb.sv
// tb/tb_wb_regfile_sb.sv - directed stimulus with queued expectations checked by a negedge monitor
module tb_wb_regfile_sb;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    typedef struct {
        int          kind;
        logic [31:0] exp;
    } chk_t;
    chk_t q[$];

    wb_regfile_sb_if bus ();

    wb_regfile_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_RS_DATA = 0, K_RT_DATA = 1, K_RS_BUSY = 2, K_RT_BUSY = 3,
                   K_FWD_VALID = 4, K_FWD_RD = 5, K_FWD_DATA = 6;

    function automatic logic [31:0] actual(int k);
        case (k)
            K_RS_DATA:   return bus.rs_data;
            K_RT_DATA:   return bus.rt_data;
            K_RS_BUSY:   return {31'd0, bus.rs_busy};
            K_RT_BUSY:   return {31'd0, bus.rt_busy};
            K_FWD_VALID: return {31'd0, bus.wb_fwd_valid};
            K_FWD_RD:    return {27'd0, bus.wb_fwd_rd};
            default:     return bus.wb_fwd_data;
        endcase
    endfunction

    function automatic string kname(int k);
        case (k)
            K_RS_DATA:   return "rs_data";
            K_RT_DATA:   return "rt_data";
            K_RS_BUSY:   return "rs_busy";
            K_RT_BUSY:   return "rt_busy";
            K_FWD_VALID: return "wb_fwd_valid";
            K_FWD_RD:    return "wb_fwd_rd";
            default:     return "wb_fwd_data";
        endcase
    endfunction

    task automatic exp_chk(int kind, logic [31:0] v);
        chk_t c;
        c.kind = kind;
        c.exp  = v;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(logic [2:0] c, logic [4:0] rd, logic [31:0] mrd, logic [31:0] rfd);
        bus.control_signals  = c;
        bus.wb_rd            = rd;
        bus.Mem_Read_Data_WB = mrd;
        bus.Reg_File_Data_WB = rfd;
    endtask

    // Monitor: every expectation queued in a cycle is checked at that cycle's falling edge.
    initial begin
        chk_t c;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                c = q.pop_front();
                a = actual(c.kind);
                total++;
                if (a === c.exp) begin
                    passed++;
                end else begin
                    $display("FAIL %s at %0t: got %h expected %h", kname(c.kind), $time, a, c.exp);
                end
            end
        end
    end

    initial begin
        logic [31:0] byp_1234;
        logic [31:0] byp_a5a5;
`ifdef WB_BYPASS_EN
        byp_1234 = 32'h1234;
        byp_a5a5 = 32'hA5A5;
`else
        byp_1234 = 32'h0;
        byp_a5a5 = 32'h0;
`endif
        total  = 0;
        passed = 0;
        rst    = 1'b1;
        ctl(3'b000, 5'd0, 32'h0, 32'h0);
        bus.rs_addr     = '0;
        bus.rt_addr     = '0;
        bus.ld_issue    = 1'b0;
        bus.ld_issue_rd = '0;
        bus.flush       = 1'b0;

        step(); bus.rs_addr = 5'd3; bus.rt_addr = 5'd5;
        exp_chk(K_RS_DATA, 0); exp_chk(K_RT_BUSY, 0); exp_chk(K_FWD_VALID, 0);
        step(); rst = 1'b0;

        // ALU write-back to r7
        step(); ctl(3'b100, 5'd7, 32'h5555, 32'h1234); bus.rs_addr = 5'd7;
        exp_chk(K_FWD_VALID, 1); exp_chk(K_FWD_RD, 7); exp_chk(K_FWD_DATA, 32'h1234);
        exp_chk(K_RS_DATA, byp_1234);
        step(); ctl(3'b000, 5'd0, 0, 0);
        exp_chk(K_RS_DATA, 32'h1234);

        // load write-back to r3 selects memory data
        step(); ctl(3'b110, 5'd3, 32'hDEAD, 32'h1111);
        exp_chk(K_FWD_DATA, 32'hDEAD);
        step(); ctl(3'b000, 5'd0, 0, 0); bus.rs_addr = 5'd3;
        exp_chk(K_RS_DATA, 32'hDEAD);

        // register 0 is never written nor made busy
        step(); ctl(3'b110, 5'd0, 32'hFFFF_FFFF, 0); bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd0;
        bus.rs_addr = 5'd0;
        exp_chk(K_FWD_VALID, 0); exp_chk(K_RS_DATA, 0); exp_chk(K_RS_BUSY, 0);
        step(); ctl(3'b000, 5'd0, 0, 0); bus.ld_issue = 1'b0;
        exp_chk(K_RS_DATA, 0); exp_chk(K_RS_BUSY, 0);

        // load-use on r9, plus a load to r5
        step(); bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9; bus.rs_addr = 5'd9;
        exp_chk(K_RS_BUSY, 0);
        step(); bus.ld_issue_rd = 5'd5;
        exp_chk(K_RS_BUSY, 1);
        step(); bus.ld_issue = 1'b0; ctl(3'b110, 5'd9, 32'h99, 0); bus.rt_addr = 5'd5;
        exp_chk(K_RS_BUSY, 0); exp_chk(K_RT_BUSY, 1); exp_chk(K_FWD_VALID, 1);
        step(); ctl(3'b000, 5'd0, 0, 0);
        exp_chk(K_RS_BUSY, 0); exp_chk(K_RS_DATA, 32'h99);

        // set and clear of r9 together: set wins
        step(); bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd9; ctl(3'b110, 5'd9, 32'h77, 0);
        exp_chk(K_RS_BUSY, 0); exp_chk(K_RT_BUSY, 1);
        step(); bus.ld_issue = 1'b0; ctl(3'b000, 5'd0, 0, 0);
        exp_chk(K_RS_BUSY, 1); exp_chk(K_RS_DATA, 32'h77);

        // set r12 and clear r5 together
        step(); bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd12; ctl(3'b110, 5'd5, 32'h55, 0);
        exp_chk(K_RT_BUSY, 0); exp_chk(K_RS_BUSY, 1);
        step(); bus.ld_issue = 1'b0; ctl(3'b000, 5'd0, 0, 0); bus.rs_addr = 5'd12;
        exp_chk(K_RS_BUSY, 1); exp_chk(K_RT_BUSY, 0); exp_chk(K_RT_DATA, 32'h55);

        // flush beats a concurrent set
        step(); bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd13; bus.flush = 1'b1; bus.rs_addr = 5'd9;
        exp_chk(K_RS_BUSY, 1);
        step(); bus.ld_issue = 1'b0; bus.flush = 1'b0; bus.rs_addr = 5'd12; bus.rt_addr = 5'd13;
        exp_chk(K_RS_BUSY, 0); exp_chk(K_RT_BUSY, 0);

        // read-during-write on r4, and a fresh load pending on r5
        step(); bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd5; ctl(3'b100, 5'd4, 0, 32'hA5A5);
        bus.rt_addr = 5'd4;
        exp_chk(K_RT_DATA, byp_a5a5);
        step(); bus.ld_issue = 1'b0; ctl(3'b000, 5'd0, 0, 0); bus.rs_addr = 5'd5;
        exp_chk(K_RS_BUSY, 1); exp_chk(K_RT_DATA, 32'hA5A5);
        step(); bus.rt_addr = 5'd3;
        exp_chk(K_RS_BUSY, 1); exp_chk(K_RT_DATA, 32'hDEAD);

        // asynchronous reset between clock edges
        step(); rst = 1'b1;
        exp_chk(K_RS_BUSY, 0); exp_chk(K_RT_DATA, 0);
        step(); rst = 1'b0; bus.rs_addr = 5'd7;
        exp_chk(K_RS_DATA, 0); exp_chk(K_RT_DATA, 0);

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
